// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the fetch stage and the control unit: opcodes,
// instruction field positions and fetch FSM state encodings.
package instr_fetch_unit_pkg;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_ADD    = 4'h1;
    localparam logic [3:0] OP_SUB    = 4'h2;
    localparam logic [3:0] OP_AND    = 4'h3;
    localparam logic [3:0] OP_OR     = 4'h4;
    localparam logic [3:0] OP_XOR    = 4'h5;
    localparam logic [3:0] OP_LD     = 4'h6;
    localparam logic [3:0] OP_ST     = 4'h7;
    localparam logic [3:0] OP_BEQ    = 4'h8;
    localparam logic [3:0] OP_BNE    = 4'h9;
    // Control unit drives every enable inactive on this opcode.
    localparam logic [3:0] OP_BUBBLE = 4'b1010;
    localparam logic [3:0] OP_JMP    = 4'hB;
    localparam logic [3:0] OP_JAL    = 4'hC;
    localparam logic [3:0] OP_LI     = 4'hD;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RS1_MSB = 8;
    localparam int RS1_LSB = 6;
    localparam int RS2_MSB = 5;
    localparam int RS2_LSB = 3;

    typedef logic [2:0] fetch_state_t;
    localparam fetch_state_t ST_IDLE   = 3'd0;
    localparam fetch_state_t ST_FETCH  = 3'd1;
    localparam fetch_state_t ST_ISSUE  = 3'd2;
    localparam fetch_state_t ST_SQUASH = 3'd3;
    localparam fetch_state_t ST_HALT   = 3'd4;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory read port: active-low chip-select/output-enable with a
// ready strobe. The fetch unit is the master, the memory the slave.
interface instr_fetch_unit_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
);
    logic               n_imem_cs;
    logic               n_imem_oe;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               imem_ready;

    modport master (
        output n_imem_cs, n_imem_oe, imem_addr,
        input  imem_rdata, imem_ready
    );

    modport slave (
        input  n_imem_cs, n_imem_oe, imem_addr,
        output imem_rdata, imem_ready
    );
endinterface

// File: rtl/instr_fetch_unit_fetch_watchdog.sv
// Counts consecutive memory wait cycles and flags expiry on the cycle that
// would be the TIMEOUT_CYC-th wait. Used only when FETCH_TIMEOUT_EN is defined.
module fetch_watchdog #(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic clk,
    input  logic n_rst,
    input  logic waiting_i,
    input  logic clear_i,
    output logic expire_o
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (waiting_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expire_o = waiting_i && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, memory read handshake, instruction register.
// Define FETCH_TIMEOUT_EN to enable the memory wait watchdog and HALT state.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter int              INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
`ifdef FETCH_TIMEOUT_EN
    ,
    parameter int              TIMEOUT_CYC = 15
`endif
) (
    input  logic                 clk,
    input  logic                 n_rst,
    instr_fetch_unit_if.master   imem,
    input  logic                 stall,
    input  logic                 redirect_en,
    input  logic [PC_W-1:0]      redirect_pc,
    output logic [3:0]           op_code,
    output logic [INSTR_W-1:0]   instr,
    output logic                 instr_valid,
    output logic [PC_W-1:0]      pc_out,
    output logic                 fetch_err
);
    fetch_state_t       state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    fetch_addr_q, fetch_addr_d;
    logic [PC_W-1:0]    pc_out_q, pc_out_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               valid_q, valid_d;
    logic               timeout;
    logic               mem_active;

`ifdef FETCH_TIMEOUT_EN
    logic waiting;
    logic wd_clear;
    logic fetch_err_q;

    assign waiting  = ((state_q == ST_FETCH) || (state_q == ST_SQUASH)) && !imem.imem_ready;
    assign wd_clear = imem.imem_ready || ((state_q != ST_FETCH) && (state_d == ST_FETCH));

    fetch_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_fetch_watchdog (
        .clk       (clk),
        .n_rst     (n_rst),
        .waiting_i (waiting),
        .clear_i   (wd_clear),
        .expire_o  (timeout)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            fetch_err_q <= 1'b0;
        end else if (timeout) begin
            fetch_err_q <= 1'b1;
        end
    end

    assign fetch_err = fetch_err_q;
`else
    assign timeout   = 1'b0;
    assign fetch_err = 1'b0;
`endif

    always_comb begin
        // NOTE: every next-state value defaults to hold so no path through the case infers a latch.
        state_d      = state_q;
        pc_d         = pc_q;
        fetch_addr_d = fetch_addr_q;
        pc_out_d     = pc_out_q;
        ir_d         = ir_q;
        valid_d      = valid_q;

        case (state_q)
            ST_IDLE: begin
                fetch_addr_d = pc_q;
                state_d      = ST_FETCH;
            end
            ST_FETCH: begin
                if (timeout) begin
                    valid_d = 1'b0;
                    state_d = ST_HALT;
                end else if (redirect_en) begin
                    pc_d = redirect_pc;
                    if (imem.imem_ready) begin
                        fetch_addr_d = redirect_pc;
                    end else begin
                        state_d = ST_SQUASH;
                    end
                end else if (imem.imem_ready) begin
                    ir_d     = imem.imem_rdata;
                    pc_out_d = fetch_addr_q;
                    valid_d  = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (redirect_en) begin
                    pc_d         = redirect_pc;
                    fetch_addr_d = redirect_pc;
                    valid_d      = 1'b0;
                    state_d      = ST_FETCH;
                end else if (!stall) begin
                    pc_d         = pc_q + PC_W'(1);
                    fetch_addr_d = pc_q + PC_W'(1);
                    valid_d      = 1'b0;
                    state_d      = ST_FETCH;
                end
            end
            ST_SQUASH: begin
                // The in-flight read must complete on its original address before refetching.
                if (redirect_en) begin
                    pc_d = redirect_pc;
                end
                if (timeout) begin
                    valid_d = 1'b0;
                    state_d = ST_HALT;
                end else if (imem.imem_ready) begin
                    fetch_addr_d = pc_d;
                    state_d      = ST_FETCH;
                end
            end
            ST_HALT: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!n_rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            fetch_addr_q <= RESET_PC;
            pc_out_q     <= RESET_PC;
            ir_q         <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_addr_q <= fetch_addr_d;
            pc_out_q     <= pc_out_d;
            ir_q         <= ir_d;
            valid_q      <= valid_d;
        end
    end

    // Strobes decode straight from the state register, so reset releases them at once.
    assign mem_active     = (state_q == ST_FETCH) || (state_q == ST_SQUASH);
    assign imem.n_imem_cs = !mem_active;
    assign imem.n_imem_oe = !mem_active;
    assign imem.imem_addr = fetch_addr_q;

    assign instr       = ir_q;
    assign instr_valid = valid_q;
    assign pc_out      = pc_out_q;
    assign op_code     = valid_q ? ir_q[INSTR_W-1 -: 4] : OP_BUBBLE;

endmodule
